mac_lookup_req: RTL and testbench
=================================

// Module: mac_lookup_req
// PURPOSE
// - Request side of the MAC table. Parses DA/SA from a per-frame header byte stream.
// - Hashes both addresses to table indices and issues one learn+lookup request per frame.
// - Waits for the table response, then emits a forwarding port mask for the frame.
// - Sits between the ingress port mux and the MAC table.
// PARAMETERS
// - pNUM_PORTS   4    number of switch ports; port id width = $clog2(pNUM_PORTS)
// - pADDR_WIDTH  14   table index width (hash output width)
// - pTIMEOUT     64   max cycles in WAIT before giving up and flooding
// PORTS
// - iclk          in   1      clock
// - irst_n        in   1      async active-low reset
// - ivalid        in   1      header byte valid
// - idata         in   8      header byte, byte0 = DA MSB ... byte11 = SA LSB
// - isof          in   1      first byte of a frame header (qualified by ivalid)
// - ieof          in   1      upstream frame end (qualified by ivalid)
// - ipnum         in   PW     ingress port id; sampled with isof byte
// - ohdr_ready    out  1      byte consumed when ivalid & ohdr_ready
// - oreq_valid    out  1      table request valid
// - oreq_pnum     out  PW     ingress port of request
// - oreq_sa       out  pADDR_WIDTH   hashed SA index
// - oreq_da       out  pADDR_WIDTH   hashed DA index
// - iresp_ready   in   1      table response strobe (1 cycle)
// - iresp_hit     in   1      DA entry valid and not aged
// - iresp_pnum    in   PW     port stored for DA
// - odec_valid    out  1      decision valid; held until idec_ready
// - odec_mask     out  pNUM_PORTS    egress port mask
// - idec_ready    in   1      decision accepted
// - ocnt_frames   out  16     decisions issued (saturating)
// - ocnt_miss     out  16     floods due to miss or timeout (saturating)
// - ocnt_drop     out  16     short headers dropped (saturating)
// BEHAVIOUR
// - Reset, async: FSM=IDLE, every output 0 except ohdr_ready=1.
// - FSM IDLE->HDR on ivalid&isof. Byte idx=0; capture byte and ipnum.
// - HDR: each accepted byte shifts into the 96-bit header; idx++.
//   - idx==11 accepted -> REQ.
//   - isof in HDR restarts at idx 0 with new ipnum.
//   - ieof before byte 11 -> drop frame, ocnt_drop++, go IDLE.
// - ohdr_ready=1 only in IDLE/HDR.
// - Hash: XOR of consecutive pADDR_WIDTH-bit slices of the 48-bit MAC, LSB first.
//   - Last slice zero-padded.
//   - Registered: oreq_* valid the cycle after byte 11.
// - REQ: oreq_valid=1 exactly 1 cycle -> WAIT; timeout counter cleared.
// - WAIT: iresp_ready -> DEC with the response registered.
//   - Counter reaching pTIMEOUT-1 without a response -> DEC as miss.
//   - A late iresp_ready outside WAIT is ignored.
// - DEC mask, ingress bit always cleared:
//   - DA group bit (byte0[0]) set: flood = all ones minus ingress.
//   - Hit and iresp_pnum != ingress: one-hot(iresp_pnum).
//   - Hit and iresp_pnum == ingress: mask 0 (filter).
//   - Miss or timeout: flood, ocnt_miss++.
// - odec_valid held with a stable mask until idec_ready.
//   - Accept cycle: ocnt_frames++, go IDLE, ohdr_ready=1 next cycle.
//   - Latency: last byte -> oreq_valid 1 cycle; iresp_ready -> odec_valid 1 cycle.
// - Counters saturate at 16'hFFFF.
// - Reset mid-frame returns to IDLE immediately; any pending request is abandoned.
// CONFIGURATION
// - MAC_LOOKUP_STATS_EN defined: the three counters are implemented as above.
// - Undefined: no counter flops; ocnt_* tied to 0. All other behaviour is identical.
// TESTING
// - Unicast hit: DA=00:11:22:33:44:55, SA=..:01, port 0; resp hit, pnum 2 -> mask 4'b0100.
// - Broadcast DA FF:FF:FF:FF:FF:FF from port 1, any response -> mask 4'b1101.
// - Miss: iresp_hit=0, ingress 3 -> mask 4'b0111; ocnt_miss=1.
// - Timeout: no iresp_ready for 64 cycles -> flood at cycle 65; a later iresp_ready is ignored.
// - Short header: ieof on byte 5 -> no oreq_valid, ocnt_drop=1.
//   A new isof mid-header restarts capture, and the hash matches the second header.
// - Backpressure: idec_ready low 10 cycles -> odec_mask stable, ohdr_ready=0; then 1 frame counted.

Source files
------------

// File: rtl/mac_lookup_req_if.sv
// Header byte stream in, table request/response and forwarding decision out, plus statistics.
interface mac_lookup_req_if #(
   parameter int pNUM_PORTS  = 4,
   parameter int pADDR_WIDTH = 14
);
   localparam int PW = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;

   logic                   ivalid;
   logic [7:0]             idata;
   logic                   isof;
   logic                   ieof;
   logic [PW-1:0]          ipnum;
   logic                   ohdr_ready;
   logic                   oreq_valid;
   logic [PW-1:0]          oreq_pnum;
   logic [pADDR_WIDTH-1:0] oreq_sa;
   logic [pADDR_WIDTH-1:0] oreq_da;
   logic                   iresp_ready;
   logic                   iresp_hit;
   logic [PW-1:0]          iresp_pnum;
   logic                   odec_valid;
   logic [pNUM_PORTS-1:0]  odec_mask;
   logic                   idec_ready;
   logic [15:0]            ocnt_frames;
   logic [15:0]            ocnt_miss;
   logic [15:0]            ocnt_drop;

   modport slave (
      input  ivalid, idata, isof, ieof, ipnum, iresp_ready, iresp_hit, iresp_pnum, idec_ready,
      output ohdr_ready, oreq_valid, oreq_pnum, oreq_sa, oreq_da, odec_valid, odec_mask,
      output ocnt_frames, ocnt_miss, ocnt_drop
   );

   modport master (
      output ivalid, idata, isof, ieof, ipnum, iresp_ready, iresp_hit, iresp_pnum, idec_ready,
      input  ohdr_ready, oreq_valid, oreq_pnum, oreq_sa, oreq_da, odec_valid, odec_mask,
      input  ocnt_frames, ocnt_miss, ocnt_drop
   );
endinterface

// File: rtl/mac_lookup_req.sv
// MAC table request side: parse DA/SA, hash, one request per frame, port mask out (1 cycle after last byte / response).
// Header input stalls from request until the decision is accepted; MAC_LOOKUP_STATS_EN enables the saturating counters.
module mac_lookup_req #(
   parameter int pNUM_PORTS  = 4,
   parameter int pADDR_WIDTH = 14,
   parameter int pTIMEOUT    = 64
) (
   input  logic            iclk,
   input  logic            irst_n,
   mac_lookup_req_if.slave bus
);
   localparam int PW  = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;
   localparam int TW  = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
   localparam int NSL = (48 + pADDR_WIDTH - 1) / pADDR_WIDTH;
   localparam logic [TW-1:0] TLAST = TW'(pTIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_REQ, S_WAIT, S_DEC} state_t;

   function automatic logic [pADDR_WIDTH-1:0] hash48(input logic [47:0] mac);
      logic [NSL*pADDR_WIDTH-1:0] pad;
      logic [pADDR_WIDTH-1:0]     h;
      pad       = '0;
      pad[47:0] = mac;
      h         = '0;
      for (int i = 0; i < NSL; i++) h = h ^ pad[i*pADDR_WIDTH +: pADDR_WIDTH];
      return h;
   endfunction

   function automatic logic [pNUM_PORTS-1:0] onehot(input logic [PW-1:0] p);
      logic [pNUM_PORTS-1:0] m;
      m    = '0;
      m[p] = 1'b1;
      return m;
   endfunction

   state_t                 state_q;
   logic [3:0]             idx_q;
   logic [87:0]            hdr_q;
   logic [PW-1:0]          pnum_q;
   logic                   group_q;
   logic [TW-1:0]          timer_q;
   logic                   ohdr_ready_q;
   logic                   oreq_valid_q;
   logic [PW-1:0]          oreq_pnum_q;
   logic [pADDR_WIDTH-1:0] oreq_sa_q;
   logic [pADDR_WIDTH-1:0] oreq_da_q;
   logic                   odec_valid_q;
   logic [pNUM_PORTS-1:0]  odec_mask_q;

   logic [95:0]            hdr_d;
   logic                   byte_acc;
   logic                   last_byte;
   logic                   resp_hit;
   logic                   dec_go;
   logic [pNUM_PORTS-1:0]  flood;
   logic [pNUM_PORTS-1:0]  dec_mask_d;

   always_comb begin
      hdr_d     = {hdr_q, bus.idata};
      byte_acc  = bus.ivalid && ohdr_ready_q;
      last_byte = (state_q == S_HDR) && !bus.isof && (idx_q == 4'd11);
      resp_hit  = bus.iresp_ready && bus.iresp_hit;
      dec_go    = (state_q == S_WAIT) && (bus.iresp_ready || (timer_q == TLAST));
      flood     = ~onehot(pnum_q);
      // Masking a one-hot hit with the flood mask filters hits back to the ingress port.
      if (group_q)       dec_mask_d = flood;
      else if (resp_hit) dec_mask_d = onehot(bus.iresp_pnum) & flood;
      else               dec_mask_d = flood;
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         hdr_q        <= '0;
         pnum_q       <= '0;
         group_q      <= 1'b0;
         timer_q      <= '0;
         ohdr_ready_q <= 1'b1;
         oreq_valid_q <= 1'b0;
         oreq_pnum_q  <= '0;
         oreq_sa_q    <= '0;
         oreq_da_q    <= '0;
         odec_valid_q <= 1'b0;
         odec_mask_q  <= '0;
      end else begin
         if (byte_acc) hdr_q <= hdr_d[87:0];
         case (state_q)
            S_IDLE, S_HDR: begin
               if (byte_acc) begin
                  if (bus.isof) begin
                     pnum_q  <= bus.ipnum;
                     idx_q   <= 4'd1;
                     state_q <= bus.ieof ? S_IDLE : S_HDR;
                  end else if (state_q == S_HDR) begin
                     if (last_byte) begin
                        oreq_valid_q <= 1'b1;
                        oreq_pnum_q  <= pnum_q;
                        oreq_da_q    <= hash48(hdr_d[95:48]);
                        oreq_sa_q    <= hash48(hdr_d[47:0]);
                        group_q      <= hdr_d[88];
                        ohdr_ready_q <= 1'b0;
                        state_q      <= S_REQ;
                     end else if (bus.ieof) begin
                        state_q <= S_IDLE;
                     end else begin
                        idx_q <= idx_q + 4'd1;
                     end
                  end
               end
            end
            S_REQ: begin
               oreq_valid_q <= 1'b0;
               timer_q      <= '0;
               state_q      <= S_WAIT;
            end
            S_WAIT: begin
               if (dec_go) begin
                  odec_valid_q <= 1'b1;
                  odec_mask_q  <= dec_mask_d;
                  state_q      <= S_DEC;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_DEC: begin
               if (bus.idec_ready) begin
                  odec_valid_q <= 1'b0;
                  ohdr_ready_q <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ohdr_ready = ohdr_ready_q;
   assign bus.oreq_valid = oreq_valid_q;
   assign bus.oreq_pnum  = oreq_pnum_q;
   assign bus.oreq_sa    = oreq_sa_q;
   assign bus.oreq_da    = oreq_da_q;
   assign bus.odec_valid = odec_valid_q;
   assign bus.odec_mask  = odec_mask_q;

`ifdef MAC_LOOKUP_STATS_EN
   logic        frame_ev;
   logic        miss_ev;
   logic        drop_ev;
   logic [15:0] cnt_frames_q;
   logic [15:0] cnt_miss_q;
   logic [15:0] cnt_drop_q;

   always_comb begin
      frame_ev = (state_q == S_DEC) && bus.idec_ready;
      miss_ev  = dec_go && !group_q && !resp_hit;
      drop_ev  = byte_acc && bus.ieof && !last_byte && (bus.isof || (state_q == S_HDR));
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         cnt_frames_q <= '0;
         cnt_miss_q   <= '0;
         cnt_drop_q   <= '0;
      end else begin
         if (frame_ev && (cnt_frames_q != 16'hFFFF)) cnt_frames_q <= cnt_frames_q + 16'd1;
         if (miss_ev  && (cnt_miss_q   != 16'hFFFF)) cnt_miss_q   <= cnt_miss_q + 16'd1;
         if (drop_ev  && (cnt_drop_q   != 16'hFFFF)) cnt_drop_q   <= cnt_drop_q + 16'd1;
      end
   end

   assign bus.ocnt_frames = cnt_frames_q;
   assign bus.ocnt_miss   = cnt_miss_q;
   assign bus.ocnt_drop   = cnt_drop_q;
`else
   assign bus.ocnt_frames = '0;
   assign bus.ocnt_miss   = '0;
   assign bus.ocnt_drop   = '0;
`endif

endmodule

// File: tb/tb_mac_lookup_req.sv
// Directed and randomized frames for mac_lookup_req against a bit-level hash and mask model.
module tb_mac_lookup_req;
   localparam int NP = 4;
   localparam int AW = 14;
   localparam int TO = 64;
   localparam int PW = 2;

   logic iclk   = 1'b0;
   logic irst_n = 1'b1;
   always #5 iclk = ~iclk;

   mac_lookup_req_if #(.pNUM_PORTS(NP), .pADDR_WIDTH(AW)) bus ();

   mac_lookup_req #(.pNUM_PORTS(NP), .pADDR_WIDTH(AW), .pTIMEOUT(TO)) dut (
      .iclk  (iclk),
      .irst_n(irst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int m_frames = 0;
   int m_miss = 0;
   int m_drop = 0;

   // Hash bit k is the parity of every MAC bit whose position is k modulo AW.
   function automatic logic [AW-1:0] ref_hash(input logic [47:0] mac);
      logic [AW-1:0] h;
      h = '0;
      for (int b = 0; b < 48; b++) h[b % AW] = h[b % AW] ^ mac[b];
      return h;
   endfunction

   function automatic logic [15:0] cexp(input int v);
`ifdef MAC_LOOKUP_STATS_EN
      return (v > 65535) ? 16'hFFFF : 16'(v);
`else
      return (v < 0) ? 16'hFFFF : 16'h0000;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt();
      chk("cnt_frames", 32'(bus.ocnt_frames), 32'(cexp(m_frames)));
      chk("cnt_miss",   32'(bus.ocnt_miss),   32'(cexp(m_miss)));
      chk("cnt_drop",   32'(bus.ocnt_drop),   32'(cexp(m_drop)));
   endtask

   task automatic idle_inputs();
      bus.ivalid = 1'b0;
      bus.isof   = 1'b0;
      bus.ieof   = 1'b0;
      bus.idata  = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof, input logic [PW-1:0] p);
      @(negedge iclk);
      bus.ivalid = 1'b1;
      bus.idata  = d;
      bus.isof   = sof;
      bus.ieof   = eof;
      bus.ipnum  = p;
   endtask

   // pre > 0 sends an aborted partial header from another port before the real one.
   task automatic send_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [PW-1:0] p,
                           input int eof_at, input int pre);
      logic [95:0] h;
      h = {da, sa};
      for (int i = 0; i < pre; i++) send_byte(8'($urandom), i == 0, 1'b0, p ^ 2'd1);
      for (int i = 0; i < 12; i++) begin
         send_byte(h[95-8*i -: 8], i == 0, i == eof_at, p);
         if (i == eof_at) break;
      end
   endtask

   task automatic run_frame(input logic [47:0] da, input logic [47:0] sa, input logic [PW-1:0] p,
                            input logic tmo, input logic hit, input logic [PW-1:0] rp,
                            input int rdly, input int bp, input int pre);
      logic [NP-1:0] exp_mask;
      logic          early;
      early = 1'b0;
      send_hdr(da, sa, p, -1, pre);
      @(negedge iclk);
      idle_inputs();
      chk("req_valid",  32'(bus.oreq_valid), 32'd1);
      chk("req_da",     32'(bus.oreq_da),    32'(ref_hash(da)));
      chk("req_sa",     32'(bus.oreq_sa),    32'(ref_hash(sa)));
      chk("req_pnum",   32'(bus.oreq_pnum),  32'(p));
      chk("hdr_rdy_req", 32'(bus.ohdr_ready), 32'd0);
      @(negedge iclk);
      chk("req_pulse", 32'(bus.oreq_valid), 32'd0);
      if (!tmo) begin
         repeat (rdly) @(negedge iclk);
         bus.iresp_ready = 1'b1;
         bus.iresp_hit   = hit;
         bus.iresp_pnum  = rp;
         @(negedge iclk);
         bus.iresp_ready = 1'b0;
         bus.iresp_hit   = 1'b0;
      end else begin
         for (int c = 0; c < TO - 1; c++) begin
            @(negedge iclk);
            if (bus.odec_valid !== 1'b0) early = 1'b1;
         end
         @(negedge iclk);
         chk("timeout_early", 32'(early), 32'd0);
      end
      if (da[40]) begin
         exp_mask    = '1;
         exp_mask[p] = 1'b0;
      end else if (!tmo && hit) begin
         exp_mask = '0;
         if (rp != p) exp_mask[rp] = 1'b1;
      end else begin
         exp_mask    = '1;
         exp_mask[p] = 1'b0;
         m_miss++;
      end
      chk("dec_valid", 32'(bus.odec_valid), 32'd1);
      chk("dec_mask",  32'(bus.odec_mask),  32'(exp_mask));
      for (int c = 0; c < bp; c++) begin
         bus.iresp_ready = (c == 0);
         bus.iresp_hit   = 1'b1;
         bus.iresp_pnum  = p + 2'd1;
         @(negedge iclk);
         chk("bp_valid",   32'(bus.odec_valid), 32'd1);
         chk("bp_mask",    32'(bus.odec_mask),  32'(exp_mask));
         chk("bp_hdr_rdy", 32'(bus.ohdr_ready), 32'd0);
      end
      bus.iresp_ready = 1'b0;
      bus.iresp_hit   = 1'b0;
      bus.idec_ready  = 1'b1;
      @(negedge iclk);
      bus.idec_ready = 1'b0;
      m_frames++;
      chk("dec_done",     32'(bus.odec_valid), 32'd0);
      chk("hdr_rdy_back", 32'(bus.ohdr_ready), 32'd1);
      chk_cnt();
   endtask

   initial begin
      logic [47:0] da;
      logic [47:0] sa;
      logic        seen;
      idle_inputs();
      bus.ipnum       = '0;
      bus.iresp_ready = 1'b0;
      bus.iresp_hit   = 1'b0;
      bus.iresp_pnum  = '0;
      bus.idec_ready  = 1'b0;

      #2 irst_n = 1'b0;
      repeat (2) @(negedge iclk);
      chk("rst_hdr_rdy",   32'(bus.ohdr_ready), 32'd1);
      chk("rst_req_valid", 32'(bus.oreq_valid), 32'd0);
      chk("rst_req_da",    32'(bus.oreq_da),    32'd0);
      chk("rst_dec_valid", 32'(bus.odec_valid), 32'd0);
      chk("rst_dec_mask",  32'(bus.odec_mask),  32'd0);
      chk_cnt();
      irst_n = 1'b1;

      // unicast hit, broadcast, miss, filter, timeout, backpressure
      run_frame(48'h001122334455, 48'h02AABBCCDD01, 2'd0, 1'b0, 1'b1, 2'd2, 0, 2, 0);
      run_frame(48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 2'd1, 1'b0, 1'b1, 2'd1, 3, 0, 0);
      run_frame(48'h0200DEADBEEF, 48'h001122334466, 2'd3, 1'b0, 1'b0, 2'd0, 1, 1, 0);
      run_frame(48'h001122334455, 48'h02AABBCCDD01, 2'd2, 1'b0, 1'b1, 2'd2, 0, 1, 0);
      run_frame(48'h00A0B0C0D0E0, 48'h123456789ABC, 2'd2, 1'b1, 1'b0, 2'd0, 0, 3, 0);
      run_frame(48'h00CAFE001234, 48'h00FEED005678, 2'd1, 1'b0, 1'b1, 2'd3, 2, 10, 0);

      // short header dropped
      send_hdr(48'h001122334455, 48'h000000000001, 2'd0, 5, 0);
      @(negedge iclk);
      idle_inputs();
      m_drop++;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (bus.oreq_valid !== 1'b0) seen = 1'b1;
         @(negedge iclk);
      end
      chk("drop_no_req",  32'(seen), 32'd0);
      chk("drop_hdr_rdy", 32'(bus.ohdr_ready), 32'd1);
      chk_cnt();

      // restart mid-header: request must reflect the second header only
      run_frame(48'h3C0011223344, 48'h5A5A5A5A5A5A, 2'd2, 1'b0, 1'b1, 2'd0, 0, 0, 4);

      for (int n = 0; n < 40; n++) begin
         da     = {$urandom, 16'($urandom)};
         da[40] = ($urandom_range(0, 3) == 0);
         sa     = {$urandom, 16'($urandom)};
         run_frame(da, sa, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                   1'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 10),
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0);
      end

      // reset mid-frame abandons everything
      send_hdr(48'h001122334455, 48'h000000000001, 2'd1, -1, 0);
      @(negedge iclk);
      idle_inputs();
      irst_n = 1'b0;
      #1;
      m_frames = 0;
      m_miss   = 0;
      m_drop   = 0;
      chk("mrst_hdr_rdy",   32'(bus.ohdr_ready), 32'd1);
      chk("mrst_req_valid", 32'(bus.oreq_valid), 32'd0);
      chk("mrst_dec_valid", 32'(bus.odec_valid), 32'd0);
      chk_cnt();
      @(negedge iclk);
      irst_n = 1'b1;
      run_frame(48'h001122334455, 48'h02AABBCCDD01, 2'd3, 1'b0, 1'b0, 2'd0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
